waterfall_write_scheduler: RTL and testbench

Sequences writes of incoming FFT magnitude rows into the banked waterfall RAM that the display path reads. Owns the circular row pointer and publishes `oldest_fft_idx` to the display system. Each completed row is committed only at a display frame boundary, so the waterfall scrolls by exactly one row per commit and never mid-frame. Sits between the FFT magnitude/quantiser output and the RAM write ports.

---
 rtl/waterfall_write_scheduler.sv | 134 +++++++++++++
 tb/tb_waterfall_write_scheduler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/waterfall_write_scheduler.sv
// Streams FFT magnitude rows into the banked circular waterfall RAM and advances the oldest-row pointer only on a display vsync edge.
// Writes and row_err are registered (1 cycle after the handshake); s_ready is low from row completion until the commit edge.
module waterfall_write_scheduler #(
  parameter int FFT_SIZE       = 256,
  parameter int DATA_WIDTH     = 4,
  parameter int NO_FFTS        = 50,
  parameter int NO_BANKS       = 2,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int IDX_WIDTH      = $clog2(NO_FFTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     s_data,
  input  logic                      s_valid,
  input  logic                      s_last,
  output logic                      s_ready,
  input  logic                      vsync,
  output logic                      wr_en,
  output logic [NO_BANKS-1:0]       wr_bank,
  output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [IDX_WIDTH-1:0]      oldest_fft_idx,
  output logic                      row_err
);

  localparam int BINS          = FFT_SIZE / 2;
  localparam int BIN_W         = $clog2(BINS);
  localparam int ROWS_PER_BANK = (1 << RAM_ADDR_WIDTH) / BINS;

  localparam logic [BIN_W-1:0]     LAST_BIN = BIN_W'(BINS - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NO_FFTS - 1);

  typedef enum logic {
    FILL,
    WAIT_FRAME
  } state_t;

  state_t                    state_q, state_d;
  logic [BIN_W-1:0]          bin_cnt_q, bin_cnt_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic                      vsync_prev_q, vsync_prev_d;
  logic                      wr_en_q, wr_en_d;
  logic [NO_BANKS-1:0]       wr_bank_q, wr_bank_d;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      row_err_q, row_err_d;

  logic                      accept;
  logic                      is_last_bin;
  logic                      row_done;
  logic                      vsync_rise;
  logic [RAM_ADDR_WIDTH-1:0] row_base;
  logic [NO_BANKS-1:0]       row_bank;

  assign s_ready     = (state_q == FILL) && !reset;
  assign accept      = s_valid && s_ready;
  assign is_last_bin = (bin_cnt_q == LAST_BIN);
  assign row_done    = accept && (s_last || is_last_bin);
  assign vsync_rise  = vsync && !vsync_prev_q;

  // The row being filled is always the oldest one; it becomes visible only after commit.
  always_comb begin
    row_base = RAM_ADDR_WIDTH'((32'(idx_q) % ROWS_PER_BANK) * BINS);
    row_bank = NO_BANKS'(1) << (32'(idx_q) / ROWS_PER_BANK);
  end

  always_comb begin
    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    idx_d        = idx_q;
    vsync_prev_d = vsync;
    wr_en_d      = accept;
    wr_bank_d    = wr_bank_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    row_err_d    = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          wr_bank_d = row_bank;
          wr_addr_d = row_base + RAM_ADDR_WIDTH'(bin_cnt_q);
          wr_data_d = s_data;
          bin_cnt_d = bin_cnt_q + 1'b1;
        end
        if (row_done) begin
          bin_cnt_d = '0;
          row_err_d = s_last ^ is_last_bin;
          state_d   = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        // An edge seen in the completion cycle was consumed in FILL, so commit needs a fresh edge.
        if (vsync_rise) begin
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      bin_cnt_q    <= '0;
      idx_q        <= '0;
      vsync_prev_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      row_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      idx_q        <= idx_d;
      vsync_prev_q <= vsync_prev_d;
      wr_en_q      <= wr_en_d;
      wr_bank_q    <= wr_bank_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      row_err_q    <= row_err_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_bank        = wr_bank_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign oldest_fft_idx = idx_q;
  assign row_err        = row_err_q;

endmodule

// File: tb/tb_waterfall_write_scheduler.sv
// Directed bench: per-cycle vectors (inputs plus expected outputs) for reset, row fill, commit, wrap and length errors.
module tb_waterfall_write_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        vsync = 1'b0;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        row_err;

  always #5 clk = ~clk;

  waterfall_write_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .vsync          (vsync),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .row_err        (row_err)
  );

  typedef struct {
    logic        rst, vld, last, vs;
    logic [3:0]  dat;
    logic        e_rdy, e_wen;
    logic [1:0]  e_bank;
    logic [11:0] e_addr;
    logic [3:0]  e_dat;
    logic [5:0]  e_old;
    logic        e_err;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int m_old = 0;
  vec_t tbl[7];

  function automatic vec_t mk(input logic rst, vld, last, vs, input logic [3:0] dat,
                              input logic e_rdy, e_wen, input logic [1:0] e_bank,
                              input logic [11:0] e_addr, input logic [3:0] e_dat,
                              input logic [5:0] e_old, input logic e_err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.last = last; v.vs = vs; v.dat = dat;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_bank = e_bank; v.e_addr = e_addr;
    v.e_dat = e_dat; v.e_old = e_old; v.e_err = e_err;
    return v;
  endfunction

  // s_ready is sampled mid-cycle before the edge; registered outputs just after the edge.
  task automatic apply(input string tag, input vec_t v);
    logic rdy_s;
    bit   ok;
    @(negedge clk);
    reset   = v.rst;
    s_valid = v.vld;
    s_last  = v.last;
    vsync   = v.vs;
    s_data  = v.dat;
    #1 rdy_s = s_ready;
    @(posedge clk);
    #1;
    ok = (rdy_s === v.e_rdy) && (wr_en === v.e_wen) &&
         (oldest_fft_idx === v.e_old) && (row_err === v.e_err);
    if (v.e_wen || v.rst)
      ok = ok && (wr_bank === v.e_bank) && (wr_addr === v.e_addr) && (wr_data === v.e_dat);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s vec %0d: got rdy=%b wen=%b bank=%b addr=%0d data=%0d old=%0d err=%b; want rdy=%b wen=%b bank=%b addr=%0d data=%0d old=%0d err=%b",
               tag, n_vec, rdy_s, wr_en, wr_bank, wr_addr, wr_data, oldest_fft_idx, row_err,
               v.e_rdy, v.e_wen, v.e_bank, v.e_addr, v.e_dat, v.e_old, v.e_err);
    end
  endtask

  // Streams n bins into the current row; optional vsync noise adds edges mid-row and on the completing bin.
  task automatic row(input int n, input bit with_last, input bit noise, input int seed);
    logic [3:0] d;
    bit         lst, done, vs, err;
    for (int b = 0; b < n; b++) begin
      d    = 4'((b + seed) % 16);
      lst  = with_last && (b == n - 1);
      done = lst || (b == 127);
      vs   = noise && ((b % 7 == 3) || (b == n - 1));
      err  = done && (lst != (b == 127));
      apply("row", mk(1'b0, 1'b1, lst, vs, d, 1'b1, 1'b1, 2'(1 << (m_old / 32)),
                      12'((m_old % 32) * 128 + b), d, 6'(m_old), err));
    end
  endtask

  task automatic commit();
    apply("wait_idle", mk(0, 0, 0, 0, 4'h0, 0, 0, 2'b00, 12'd0, 4'h0, 6'(m_old), 0));
    apply("wait_vld",  mk(0, 1, 0, 0, 4'hA, 0, 0, 2'b00, 12'd0, 4'h0, 6'(m_old), 0));
    m_old = (m_old == 49) ? 0 : m_old + 1;
    apply("vs_edge",   mk(0, 0, 0, 1, 4'h0, 0, 0, 2'b00, 12'd0, 4'h0, 6'(m_old), 0));
    apply("post_edge", mk(0, 0, 0, 0, 4'h0, 1, 0, 2'b00, 12'd0, 4'h0, 6'(m_old), 0));
  endtask

  initial begin
    tbl[0] = mk(1, 0, 0, 0, 4'h0, 0, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    tbl[1] = mk(1, 1, 1, 1, 4'h5, 0, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    tbl[2] = mk(0, 0, 0, 0, 4'h0, 1, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    tbl[3] = mk(0, 0, 0, 1, 4'h0, 1, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    tbl[4] = mk(0, 0, 0, 0, 4'h0, 1, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    tbl[5] = mk(0, 0, 0, 1, 4'h0, 1, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    tbl[6] = mk(0, 0, 0, 0, 4'h0, 1, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0);
    for (int i = 0; i < 7; i++) apply("table", tbl[i]);

    // Row 0 with data b mod 16, then rows 1..31 (one with vsync noise).
    row(128, 1'b1, 1'b0, 0);
    commit();
    for (int r = 1; r < 32; r++) begin
      row(128, 1'b1, (r == 5), r);
      commit();
    end

    // Row 32 lands in bank 1 at address 0; continue to the wrap at 49 -> 0.
    for (int r = 32; r < 50; r++) begin
      row(128, 1'b1, (r == 40), r);
      commit();
    end

    // Short row at index 0, then a long row without s_last at index 1.
    row(10, 1'b1, 1'b0, 7);
    commit();
    row(128, 1'b0, 1'b0, 2);
    commit();

    // Partial row 2 interrupted by reset; the next bin restarts at row 0 bin 0.
    row(5, 1'b0, 1'b0, 4);
    apply("mid_rst", mk(1, 1, 0, 0, 4'h3, 0, 0, 2'b00, 12'd0, 4'h0, 6'd0, 0));
    m_old = 0;
    row(3, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
